commit_pipe_queue: RTL and testbench

//  Decoupled successor of the single-register commit-to-writeback/memory pipe. Two independent

---
 rtl/commit_pipe_pkg.sv | 22 ++
 rtl/commit_fifo.sv | 78 +++++++
 rtl/commit_pipe_queue.sv | 64 ++++++
 tb/tb_commit_pipe_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pipe_pkg.sv
// Shared helpers for the commit pipe queue: ID/pointer sizing and channel payload widths.
// Imported by commit_fifo and commit_pipe_queue.
package commit_pipe_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // {ALU_result, opReg[4:0], regWrite, opwrite, ID, PC_select[1:0], JALR_target, branch_target, branch}
  function automatic int wb_width(input int dw, input int aw, input int idw);
    return dw + 5 + 1 + 1 + idw + 2 + aw + aw + 1;
  endfunction

  // {generated_address, store_data, memWrite, memRead, ID}
  function automatic int mem_width(input int dw, input int aw, input int idw);
    return aw + dw + 1 + 1 + idw;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// One buffered channel: DEPTH-entry FIFO with valid/ready handshake, sync flush and occupancy.
// COMMIT_PIPE_BYPASS_EN enables 0-cycle forwarding through an empty queue.
module commit_fifo
  import commit_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2_min1(DEPTH):0]   count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef COMMIT_PIPE_BYPASS_EN
  assign w_bypass = w_empty && out_ready && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // in_ready comes from the occupancy register only, so there is no out_ready -> in_ready path
  assign in_ready  = !w_full;
  assign out_valid = w_bypass ? in_valid : !w_empty;
  assign out_data  = w_bypass ? in_data : (w_empty ? '0 : r_mem[r_rd_ptr]);
  assign count     = r_count;

  assign w_push = in_valid && !w_full && !flush && !w_bypass;
  assign w_pop  = !w_empty && out_ready && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the output is masked to zero whenever the queue is empty
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: rtl/commit_pipe_queue.sv
// Commit-to-writeback/memory pipe: independent WB and MEM FIFO channels sharing a flush.
// Optional COMMIT_PIPE_BYPASS_EN gives 0-cycle forwarding through an empty channel.
module commit_pipe_queue
  import commit_pipe_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int ADDRESS_BITS                  = 20,
  parameter int NUMBER_OF_ACTIVE_INSTRUCTIONS = 2,
  parameter int DEPTH                         = 4
) (
  input  logic                                                          clock,
  input  logic                                                          reset,
  input  logic                                                          flush,
  input  logic                                                          wb_in_valid,
  output logic                                                          wb_in_ready,
  input  logic [wb_width(DATA_WIDTH, ADDRESS_BITS,
                 clog2_min1(NUMBER_OF_ACTIVE_INSTRUCTIONS))-1:0]        wb_in_data,
  output logic                                                          wb_out_valid,
  input  logic                                                          wb_out_ready,
  output logic [wb_width(DATA_WIDTH, ADDRESS_BITS,
                 clog2_min1(NUMBER_OF_ACTIVE_INSTRUCTIONS))-1:0]        wb_out_data,
  input  logic                                                          mem_in_valid,
  output logic                                                          mem_in_ready,
  input  logic [mem_width(DATA_WIDTH, ADDRESS_BITS,
                 clog2_min1(NUMBER_OF_ACTIVE_INSTRUCTIONS))-1:0]        mem_in_data,
  output logic                                                          mem_out_valid,
  input  logic                                                          mem_out_ready,
  output logic [mem_width(DATA_WIDTH, ADDRESS_BITS,
                 clog2_min1(NUMBER_OF_ACTIVE_INSTRUCTIONS))-1:0]        mem_out_data,
  output logic [clog2_min1(DEPTH):0]                                    wb_count,
  output logic [clog2_min1(DEPTH):0]                                    mem_count
);

  localparam int ID_W  = clog2_min1(NUMBER_OF_ACTIVE_INSTRUCTIONS);
  localparam int WB_W  = wb_width(DATA_WIDTH, ADDRESS_BITS, ID_W);
  localparam int MEM_W = mem_width(DATA_WIDTH, ADDRESS_BITS, ID_W);

  commit_fifo #(.WIDTH(WB_W), .DEPTH(DEPTH)) u_wb_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (wb_in_valid),
    .in_ready  (wb_in_ready),
    .in_data   (wb_in_data),
    .out_valid (wb_out_valid),
    .out_ready (wb_out_ready),
    .out_data  (wb_out_data),
    .count     (wb_count)
  );

  commit_fifo #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_mem_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (mem_in_valid),
    .in_ready  (mem_in_ready),
    .in_data   (mem_in_data),
    .out_valid (mem_out_valid),
    .out_ready (mem_out_ready),
    .out_data  (mem_out_data),
    .count     (mem_count)
  );

endmodule

// File: tb/tb_commit_pipe_queue.sv
// Bench for commit_pipe_queue: vector table, hand sequences and random traffic vs a queue model.
module tb_commit_pipe_queue;

  localparam int WB_W  = 83;
  localparam int MEM_W = 55;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             wb_in_valid = 1'b0;
  logic             wb_in_ready;
  logic [WB_W-1:0]  wb_in_data = '0;
  logic             wb_out_valid;
  logic             wb_out_ready = 1'b0;
  logic [WB_W-1:0]  wb_out_data;
  logic             mem_in_valid = 1'b0;
  logic             mem_in_ready;
  logic [MEM_W-1:0] mem_in_data = '0;
  logic             mem_out_valid;
  logic             mem_out_ready = 1'b0;
  logic [MEM_W-1:0] mem_out_data;
  logic [2:0]       wb_count;
  logic [2:0]       mem_count;

  int checks = 0;
  int failures = 0;

  logic [WB_W-1:0]  wb_q[$];
  logic [MEM_W-1:0] mem_q[$];

  always #5 clock = ~clock;

  commit_pipe_queue dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .wb_in_valid   (wb_in_valid),
    .wb_in_ready   (wb_in_ready),
    .wb_in_data    (wb_in_data),
    .wb_out_valid  (wb_out_valid),
    .wb_out_ready  (wb_out_ready),
    .wb_out_data   (wb_out_data),
    .mem_in_valid  (mem_in_valid),
    .mem_in_ready  (mem_in_ready),
    .mem_in_data   (mem_in_data),
    .mem_out_valid (mem_out_valid),
    .mem_out_ready (mem_out_ready),
    .mem_out_data  (mem_out_data),
    .wb_count      (wb_count),
    .mem_count     (mem_count)
  );

  typedef struct {
    logic        wv;
    logic [31:0] alu;
    logic        wr;
    logic        mv;
    logic [19:0] addr;
    logic        mr;
    logic        fl;
    int          ewc;
    logic [31:0] ewhead;
    int          emc;
    logic [19:0] emhead;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic wv, logic [31:0] alu, logic wr, logic mv, logic [19:0] addr,
                              logic mr, logic fl, int ewc, logic [31:0] ewh, int emc, logic [19:0] emh);
    vec_t v;
    v.wv = wv; v.alu = alu; v.wr = wr; v.mv = mv; v.addr = addr; v.mr = mr; v.fl = fl;
    v.ewc = ewc; v.ewhead = ewh; v.emc = emc; v.emhead = emh;
    return v;
  endfunction

  // Compare DUT against the queue model mid-cycle, then advance the model as the edge would
  task automatic tick();
    logic             exp_wv, exp_mv, w_byp, m_byp, w_push, w_pop, m_push, m_pop;
    logic [WB_W-1:0]  exp_wd;
    logic [MEM_W-1:0] exp_md;
    @(negedge clock);
    exp_wv = (wb_q.size() != 0);
    exp_wd = exp_wv ? wb_q[0] : '0;
    exp_mv = (mem_q.size() != 0);
    exp_md = exp_mv ? mem_q[0] : '0;
    w_byp = 1'b0;
    m_byp = 1'b0;
`ifdef COMMIT_PIPE_BYPASS_EN
    w_byp = (wb_q.size() == 0) && wb_out_ready && !flush;
    m_byp = (mem_q.size() == 0) && mem_out_ready && !flush;
    if (w_byp) begin exp_wv = wb_in_valid; exp_wd = wb_in_data; end
    if (m_byp) begin exp_mv = mem_in_valid; exp_md = mem_in_data; end
`endif
    chk("wb_out_valid", wb_out_valid, exp_wv);
    chk("wb_in_ready", wb_in_ready, wb_q.size() < DEPTH);
    chk("wb_count", wb_count, wb_q.size());
    if (exp_wv) chk("wb_out_data", wb_out_data, exp_wd);
    chk("mem_out_valid", mem_out_valid, exp_mv);
    chk("mem_in_ready", mem_in_ready, mem_q.size() < DEPTH);
    chk("mem_count", mem_count, mem_q.size());
    if (exp_mv) chk("mem_out_data", mem_out_data, exp_md);
    if (flush) begin
      wb_q.delete();
      mem_q.delete();
    end else begin
      w_pop  = (wb_q.size() != 0) && wb_out_ready;
      w_push = wb_in_valid && (wb_q.size() < DEPTH) && !w_byp;
      m_pop  = (mem_q.size() != 0) && mem_out_ready;
      m_push = mem_in_valid && (mem_q.size() < DEPTH) && !m_byp;
      if (w_pop) void'(wb_q.pop_front());
      if (w_push) wb_q.push_back(wb_in_data);
      if (m_pop) void'(mem_q.pop_front());
      if (m_push) mem_q.push_back(mem_in_data);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // row: wv alu wr | mv addr mr | flush | exp wb_count, wb head ALU, mem_count, mem head addr
    tbl[0]  = mk(1, 32'h11, 0, 1, 20'hA1, 0, 0, 1, 32'h11, 1, 20'hA1);
    tbl[1]  = mk(1, 32'h22, 0, 1, 20'hA2, 0, 0, 2, 32'h11, 2, 20'hA1);
    tbl[2]  = mk(1, 32'h33, 0, 1, 20'hA3, 0, 0, 3, 32'h11, 3, 20'hA1);
    tbl[3]  = mk(1, 32'h44, 0, 0, 20'h0,  0, 0, 4, 32'h11, 3, 20'hA1);
    tbl[4]  = mk(1, 32'h55, 0, 0, 20'h0,  0, 0, 4, 32'h11, 3, 20'hA1);
    tbl[5]  = mk(1, 32'h56, 1, 0, 20'h0,  0, 0, 3, 32'h22, 3, 20'hA1);
    tbl[6]  = mk(1, 32'h66, 1, 0, 20'h0,  0, 0, 3, 32'h33, 3, 20'hA1);
    tbl[7]  = mk(1, 32'h77, 1, 0, 20'h0,  0, 0, 3, 32'h44, 3, 20'hA1);
    tbl[8]  = mk(1, 32'h88, 0, 1, 20'hA4, 0, 1, 0, 32'h0,  0, 20'h0);
    tbl[9]  = mk(1, 32'h99, 0, 1, 20'hB1, 0, 0, 1, 32'h99, 1, 20'hB1);
    tbl[10] = mk(0, 32'h0,  1, 0, 20'h0,  1, 0, 0, 32'h0,  0, 20'h0);

    #12;
    chk("rst_wb_in_ready", wb_in_ready, 1'b1);
    chk("rst_wb_out_valid", wb_out_valid, 1'b0);
    chk("rst_wb_out_data", wb_out_data, '0);
    chk("rst_mem_count", mem_count, 3'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      wb_in_valid   = tbl[i].wv;
      wb_in_data    = {tbl[i].alu, {(WB_W-32){1'b0}}};
      wb_out_ready  = tbl[i].wr;
      mem_in_valid  = tbl[i].mv;
      mem_in_data   = {tbl[i].addr, {(MEM_W-20){1'b0}}};
      mem_out_ready = tbl[i].mr;
      flush         = tbl[i].fl;
      tick();
      chk($sformatf("tbl%0d_wb_count", i), wb_count, tbl[i].ewc);
      chk($sformatf("tbl%0d_mem_count", i), mem_count, tbl[i].emc);
      if (tbl[i].ewc > 0) chk($sformatf("tbl%0d_wb_head", i), wb_out_data[WB_W-1 -: 32], tbl[i].ewhead);
      if (tbl[i].emc > 0) chk($sformatf("tbl%0d_mem_head", i), mem_out_data[MEM_W-1 -: 20], tbl[i].emhead);
      if (tbl[i].ewc == DEPTH) chk($sformatf("tbl%0d_wb_full", i), wb_in_ready, 1'b0);
    end
    flush = 1'b0;

    // Empty channel with consumer ready: forwarding latency
    wb_in_valid  = 1'b1;
    wb_in_data   = {32'hAB, {(WB_W-32){1'b0}}};
    wb_out_ready = 1'b1;
    mem_in_valid = 1'b0;
    #1;
`ifdef COMMIT_PIPE_BYPASS_EN
    chk("byp_same_cycle_valid", wb_out_valid, 1'b1);
    chk("byp_same_cycle_data", wb_out_data[WB_W-1 -: 32], 32'hAB);
`else
    chk("reg_same_cycle_valid", wb_out_valid, 1'b0);
`endif
    tick();
    wb_in_valid = 1'b0;
    #1;
`ifdef COMMIT_PIPE_BYPASS_EN
    chk("byp_next_valid", wb_out_valid, 1'b0);
    chk("byp_next_count", wb_count, 3'd0);
`else
    chk("reg_next_valid", wb_out_valid, 1'b1);
    chk("reg_next_data", wb_out_data[WB_W-1 -: 32], 32'hAB);
    chk("reg_next_count", wb_count, 3'd1);
`endif
    tick();

    // Random traffic, then reset dropped mid-traffic
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 400; c++) begin
        wb_in_valid   = 1'($urandom_range(0, 1));
        wb_in_data    = WB_W'({$urandom, $urandom, $urandom});
        wb_out_ready  = ($urandom_range(0, 3) != 0);
        mem_in_valid  = 1'($urandom_range(0, 1));
        mem_in_data   = MEM_W'({$urandom, $urandom});
        mem_out_ready = ($urandom_range(0, 2) == 0);
        flush         = ($urandom_range(0, 29) == 0);
        tick();
      end
      flush = 1'b0;
      if (phase == 0) begin
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_wb_in_ready", wb_in_ready, 1'b1);
        chk("midrst_mem_in_ready", mem_in_ready, 1'b1);
        chk("midrst_wb_count", wb_count, 3'd0);
        chk("midrst_mem_count", mem_count, 3'd0);
        chk("midrst_mem_out_valid", mem_out_valid, 1'b0);
        chk("midrst_mem_out_data", mem_out_data, '0);
        wb_q.delete();
        mem_q.delete();
        wb_in_valid  = 1'b0;
        mem_in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
